io_input_ctrl: RTL and testbench

Debounced, memory-mapped controller for the 8-bit switch/key input port of the single-cycle computer. It synchronises `in_port`, runs a settle state machine so only values held stable for `DEBOUNCE_CYCLES` clocks are committed, and records which nibble changed. It serves CPU reads on the I/O address window at 0xC0–0xCC (selected by `addr[7:2]`) and raises an interrupt-style flag until software acknowledges the change.

---
 rtl/io_input_ctrl.sv | 131 +++++++++++++
 tb/tb_io_input_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_ctrl.sv
// Debounced memory-mapped input port: synchronises in_port, commits values held
// stable for DEBOUNCE_CYCLES samples, tracks changed nibbles and raises irq.
module io_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [7:0]  in_port,
  input  logic [31:0] addr,
  input  logic        rd_en,
  output logic [31:0] io_read_data,
  output logic        irq
);

  typedef enum logic {
    ST_IDLE,
    ST_SETTLE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0]       SEL_LO   = 6'b110000;
  localparam logic [5:0]       SEL_HI   = 6'b110001;
  localparam logic [5:0]       SEL_CHG  = 6'b110010;
  localparam logic [5:0]       SEL_EVT  = 6'b110011;

  state_e           state_q, state_d;
  logic [7:0]       s1_q, s2_q;
  logic [7:0]       stable_q, stable_d;
  logic [7:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       chg_q, chg_d;
  logic [7:0]       evt_q, evt_d;

  logic [5:0]       sel;
  logic             commit;
  logic [1:0]       new_bits;
  logic             chg_clr;
  logic             unused_addr;

  assign sel         = addr[7:2];
  assign unused_addr = ^{addr[31:8], addr[1:0]};
  assign chg_clr     = rd_en && (sel == SEL_CHG);

  // Two-flop synchroniser; only s2_q is ever looked at by the settle logic.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      s1_q <= 8'h00;
      s2_q <= 8'h00;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    evt_d    = evt_q;
    commit   = 1'b0;
    new_bits = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        if (s2_q != stable_q) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (s2_q == stable_q) begin
          state_d = ST_IDLE;
        end else if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit   = 1'b1;
          new_bits = {|(cand_q[7:4] ^ stable_q[7:4]), |(cand_q[3:0] ^ stable_q[3:0])};
          stable_d = cand_q;
          evt_d    = evt_q + 8'd1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A read-clear drops old flags, but bits set by a same-cycle commit survive.
    chg_d = chg_clr ? new_bits : (chg_q | new_bits);
  end

  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      stable_q <= 8'h00;
      cand_q   <= 8'h00;
      cnt_q    <= '0;
      chg_q    <= 2'b00;
      evt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      evt_q    <= evt_d;
    end
  end

  assign irq = |chg_q;

  always_comb begin
    io_read_data = 32'h0;
    unique case (sel)
      SEL_LO:  io_read_data = {28'h0, stable_q[3:0]};
      SEL_HI:  io_read_data = {28'h0, stable_q[7:4]};
      SEL_CHG: io_read_data = {30'h0, chg_q};
      SEL_EVT: io_read_data = {24'h0, evt_q};
      default: io_read_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Self-checking bench for io_input_ctrl: directed scenarios plus random traffic,
// compared against a run-length reference model of the debounce rules.
module tb_io_input_ctrl;

  localparam int D = 4;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [7:0]  in_port;
  logic [31:0] addr;
  logic        rd_en;
  logic [31:0] io_read_data;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Reference model: a value commits once the synchronised input has shown it
  // for D+1 consecutive edges while it differs from the committed value.
  logic [7:0] m_s1, m_s2, m_prev, m_stable, m_evt;
  logic [1:0] m_chg;
  int         m_run;

  always #50 io_clk = ~io_clk;

  io_input_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .io_clk      (io_clk),
    .reset       (reset),
    .in_port     (in_port),
    .addr        (addr),
    .rd_en       (rd_en),
    .io_read_data(io_read_data),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_s1 = 8'h00; m_s2 = 8'h00; m_prev = 8'h00; m_stable = 8'h00;
    m_evt = 8'h00; m_chg = 2'b00; m_run = 0;
  endtask

  task automatic model_edge();
    logic [7:0] v;
    int         run;
    logic       hit;
    logic [1:0] nb;
    if (reset) begin
      model_clear();
      return;
    end
    v   = m_s2;
    run = (m_run > 0 && v == m_prev) ? m_run + 1 : 1;
    hit = (v != m_stable) && (run >= D + 1);
    nb  = hit ? {|(v[7:4] ^ m_stable[7:4]), |(v[3:0] ^ m_stable[3:0])} : 2'b00;
    m_chg = (rd_en && addr[7:2] == 6'h32) ? nb : (m_chg | nb);
    if (hit) begin
      m_stable = v;
      m_evt    = m_evt + 8'd1;
    end
    m_prev = v;
    m_run  = run;
    m_s2   = m_s1;
    m_s1   = in_port;
  endtask

  function automatic logic [31:0] exp_read(input logic [5:0] sel);
    case (sel)
      6'h30:   return {28'h0, m_stable[3:0]};
      6'h31:   return {28'h0, m_stable[7:4]};
      6'h32:   return {30'h0, m_chg};
      6'h33:   return {24'h0, m_evt};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [31:0] saved;
    logic [5:0]  sel;
    saved = addr;
    for (int i = 0; i < 5; i++) begin
      sel  = (i == 4) ? 6'h00 : 6'(6'h30 + i);
      addr = {24'h0, sel, 2'b00};
      #1;
      check($sformatf("%s_sel%0h", tag, sel), io_read_data, exp_read(sel));
    end
    addr = saved;
    #1;
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, |m_chg});
  endtask

  task automatic step();
    model_edge();
    @(posedge io_clk);
    #1;
    check_all("model");
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] d);
    logic [31:0] saved;
    saved = addr;
    addr  = {24'h0, a};
    #1;
    d    = io_read_data;
    addr = saved;
    #1;
  endtask

  task automatic expect_rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    peek(a, d);
    check(tag, d, exp);
  endtask

  task automatic clear_chg();
    addr  = 32'hC8;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    addr  = 32'h0;
  endtask

  logic [7:0] evt_before;

  initial begin
    // Reset held with A5 on the pins, then released.
    reset = 1'b1; in_port = 8'hA5; addr = 32'h0; rd_en = 1'b0;
    model_clear();
    #1;
    check_all("rst");
    repeat (3) step();
    reset = 1'b0;
    for (int e = 0; e < 6; e++) begin
      step();
      expect_rd("rst_c0_before_commit", 8'hC0, 32'h0);
    end
    step();
    expect_rd("rst_c0", 8'hC0, 32'h5);
    expect_rd("rst_c4", 8'hC4, 32'hA);
    expect_rd("rst_c8", 8'hC8, 32'h3);
    expect_rd("rst_cc", 8'hCC, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h1);
    addr = 32'hC8; rd_en = 1'b1;
    #1;
    check("rst_c8_preclear", io_read_data, 32'h3);
    step();
    rd_en = 1'b0;
    check("rst_irq_cleared", {31'h0, irq}, 32'h0);

    // Return to 0x00, then a low-nibble change to 0x07.
    in_port = 8'h00;
    repeat (8) step();
    clear_chg();
    in_port = 8'h07;
    for (int e = 0; e < 6; e++) begin
      step();
      expect_rd("low_c8_before_commit", 8'hC8, 32'h0);
    end
    step();
    expect_rd("low_c0", 8'hC0, 32'h7);
    addr = 32'hC8; rd_en = 1'b1;
    #1;
    check("low_c8_read", io_read_data, 32'h1);
    step();
    rd_en = 1'b0;
    expect_rd("low_c8_cleared", 8'hC8, 32'h0);
    check("low_irq_cleared", {31'h0, irq}, 32'h0);

    // Glitch of three samples from 0x00 never commits.
    in_port = 8'h00;
    repeat (8) step();
    clear_chg();
    peek(8'hCC, evt_before);
    in_port = 8'h30;
    repeat (3) step();
    in_port = 8'h00;
    repeat (10) step();
    expect_rd("glitch_evt", 8'hCC, {24'h0, evt_before[7:0]});
    check("glitch_irq", {31'h0, irq}, 32'h0);

    // Bouncing 0x10/0x20, then settling at 0x20: a single high-nibble commit.
    for (int e = 0; e < 10; e++) begin
      in_port = e[0] ? 8'h20 : 8'h10;
      step();
    end
    in_port = 8'h20;
    repeat (10) step();
    expect_rd("bounce_evt", 8'hCC, {24'h0, evt_before + 8'd1});
    expect_rd("bounce_chg", 8'hC8, 32'h2);

    // Commit of a low-nibble change coinciding with a read-clear of chg=10.
    in_port = 8'h21;
    repeat (6) step();
    addr = 32'hC8; rd_en = 1'b1;
    #1;
    check("simul_c8_preclear", io_read_data, 32'h2);
    step();
    rd_en = 1'b0; addr = 32'h0;
    expect_rd("simul_chg", 8'hC8, 32'h1);
    check("simul_irq", {31'h0, irq}, 32'h1);

    // Asynchronous reset in the middle of SETTLE.
    in_port = 8'h99;
    repeat (3) step();
    #10;
    reset = 1'b1;
    in_port = 8'h00;
    model_clear();
    #1;
    check_all("midreset");
    expect_rd("midreset_cc", 8'hCC, 32'h0);
    expect_rd("midreset_c4", 8'hC4, 32'h0);
    check("midreset_irq", {31'h0, irq}, 32'h0);
    repeat (2) step();
    reset = 1'b0;
    repeat (10) step();
    expect_rd("midreset_no_commit", 8'hCC, 32'h0);

    // 256 commits wrap the event counter back to zero.
    for (int i = 0; i < 256; i++) begin
      in_port = i[0] ? 8'h02 : 8'h01;
      repeat (8) step();
    end
    expect_rd("wrap_evt", 8'hCC, 32'h0);
    expect_rd("wrap_c0", 8'hC0, 32'h2);
    expect_rd("unmapped", 8'h00, 32'h0);

    // Random traffic against the model, including random upper address bits.
    for (int i = 0; i < 600; i++) begin
      int hold;
      in_port = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'($urandom_range(0, 1)), 4'($urandom_range(0, 2))};
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        rd_en = ($urandom_range(0, 3) == 0);
        addr  = {24'($urandom), 4'hC, 2'($urandom), 2'($urandom)};
        if ($urandom_range(0, 299) == 0) reset = 1'b1;
        step();
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
